// File: rtl/operand_capture_pkg.sv
// Shared calculator definitions: entry-state encodings and default operand/debounce sizing.
package operand_capture_pkg;

  localparam int CALC_WIDTH           = 5;
  localparam int CALC_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE_A = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_READY  = 2'b10
  } state_e;

endpackage

// File: rtl/operand_capture_debounce_pulse.sv
// Load button conditioning: 2-flop synchroniser, optional debounce filter (OPERAND_CAPTURE_DEBOUNCE_EN),
// then a one-cycle pulse per accepted press. Releases never pulse.
module operand_capture_debounce_pulse
  import operand_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       load_s;
  logic       deb;
  logic       deb_dly_q;

  assign load_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      deb_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      deb_dly_q <= deb;
    end
  end

`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (load_s != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = load_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign deb        = load_s;
`endif

  assign pulse_o = deb & ~deb_dly_q;

endmodule

// File: rtl/operand_capture.sv
// Operand entry: captures A then B from the switches on each debounced load press; clear abandons entry.
// Debounce is selected by OPERAND_CAPTURE_DEBOUNCE_EN; all outputs are registered.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int WIDTH           = CALC_WIDTH,
  parameter int DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic [1:0]       stage
);

  logic             load_p;
  logic [1:0]       clr_sync_q;
  logic             clear_s;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             valid_q;

  operand_capture_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_load),
    .pulse_o(load_p)
  );

  assign clear_s = clr_sync_q[1];

  // Clear outranks a coincident load pulse; that pulse is simply dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (clear_s) begin
      state_d = ST_IDLE_A;
      a_d     = '0;
      b_d     = '0;
    end else if (load_p) begin
      case (state_q)
        ST_IDLE_A: begin
          a_d     = sw;
          state_d = ST_WAIT_B;
        end
        ST_WAIT_B: begin
          b_d     = sw;
          state_d = ST_READY;
        end
        ST_READY: begin
          a_d     = sw;
          b_d     = '0;
          state_d = ST_WAIT_B;
        end
        default: begin
          a_d     = '0;
          b_d     = '0;
          state_d = ST_IDLE_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_sync_q <= 2'b00;
      state_q    <= ST_IDLE_A;
      a_q        <= '0;
      b_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      clr_sync_q <= {clr_sync_q[0], btn_clear};
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      valid_q    <= (state_d == ST_READY);
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign stage = state_q;

endmodule

// File: tb/tb_operand_capture.sv
// Scoreboard bench for operand_capture; expected captures are queued by stimulus and checked by a monitor.
module tb_operand_capture;

`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int L = 2 + DEB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sw;
  logic       btn_load, btn_clear;
  logic [4:0] a, b;
  logic       valid;
  logic [1:0] stage;

  operand_capture #(.WIDTH(5), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
    .a(a), .b(b), .valid(valid), .stage(stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] st;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 0;
  logic [4:0] m_a = 0, m_b = 0;
  logic [1:0] m_st = 0;
  logic [12:0] prev = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_state(input int at);
    exp_t e;
    e.a = m_a; e.b = m_b; e.st = m_st; e.cyc = at;
    q.push_back(e);
  endtask

  // Entry rules: first press fills A, second fills B, a press when complete restarts with new A.
  task automatic model_load(input logic [4:0] v, input int at);
    if (m_st == 2'd0)      begin m_a = v; m_st = 2'd1; end
    else if (m_st == 2'd1) begin m_b = v; m_st = 2'd2; end
    else                   begin m_a = v; m_b = 0; m_st = 2'd1; end
    push_state(at);
  endtask

  task automatic model_clear(input int at);
    if (m_st != 2'd0) begin
      m_a = 0; m_b = 0; m_st = 0;
      push_state(at);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] cur;
    exp_t e;
    cur = {a, b, stage, valid};
    if (mon_en && cur != prev) begin
      if (q.size() == 0) begin
        chk("unexpected_output_change", int'(cur), int'(prev));
      end else begin
        e = q.pop_front();
        chk("a", a, e.a);
        chk("b", b, e.b);
        chk("stage", stage, e.st);
        chk("valid", valid, (e.st == 2'd2));
        chk("capture_cycle", cyc, e.cyc);
      end
    end
    prev = cur;
  end

  task automatic press(input logic [4:0] v);
    @(negedge clk);
    sw = v;
    btn_load = 1'b1;
    model_load(v, cyc + 1 + L);
    repeat (L + 2) @(negedge clk);
    btn_load = 1'b0;
    repeat (L + 3) @(negedge clk);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    btn_clear = 1'b1;
    model_clear(cyc + 3);
    repeat (3) @(negedge clk);
    btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset with everything asserted: outputs must be zero before any clock edge.
    rst_n = 1'b0; sw = 5'h1F; btn_load = 1'b1; btn_clear = 1'b1;
    #1;
    chk("reset_a", a, 0);
    chk("reset_b", b, 0);
    chk("reset_valid", valid, 0);
    chk("reset_stage", stage, 0);
    repeat (3) @(negedge clk);
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    repeat (L + 4) @(negedge clk);

    press(5'd19);
    press(5'd7);
    press(5'd3);

    // Bounce burst: filtered out when debounced, otherwise each rise is a capture.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      btn_load = 1'b1;
      if (DEB == 0) model_load(5'd3, cyc + 3);
      repeat (2) @(negedge clk);
      btn_load = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (L + 3) @(negedge clk);

    // Get to WAIT_B, then let clear land on the same cycle as the load pulse.
    clear_pulse();
    press(5'd12);
    @(negedge clk);
    sw = 5'd25;
    btn_load = 1'b1;
    repeat (DEB) @(negedge clk);
    btn_clear = 1'b1;
    model_clear(cyc + 3);
    repeat (5) @(negedge clk);
    btn_clear = 1'b0;
    repeat (35) @(negedge clk);
    btn_load = 1'b0;
    repeat (L + 3) @(negedge clk);
    press(5'd25);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) clear_pulse();
      else press(5'($urandom_range(0, 31)));
    end

    // Asynchronous reset in the middle of an entry.
    if (m_st == 2'd0) press(5'd9);
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", a, 0);
    chk("async_reset_b", b, 0);
    chk("async_reset_valid", valid, 0);
    chk("async_reset_stage", stage, 0);
    m_a = 0; m_b = 0; m_st = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1;
    press(5'd30);
    press(5'd1);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
